// File: rtl/mmio_mem_ctrl.sv
// Memory and I/O access controller for the MIPS150 datapath.
// It decodes execute-stage loads and stores into DMEM/IMEM byte enables, per-channel UART
// strobes and performance-counter accesses. It returns the aligned, extended load result in
// the writeback stage.
module mmio_mem_ctrl #(
    parameter int unsigned NUM_UART    = 2,
    parameter int unsigned UART_STRIDE = 32,
    parameter int unsigned IO_BIT      = 31,
    parameter int unsigned IMEM_BIT    = 30,
    parameter int unsigned DMEM_BIT    = 28,
    parameter logic [31:0] CNT_OFFSET  = 32'h400,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_stall,
    input  logic                  i_is_load,
    input  logic                  i_is_store,
    input  logic [31:0]           i_addr,
    input  logic [1:0]            i_size,
    input  logic                  i_load_signed,
    input  logic [31:0]           i_store_data,
    input  logic                  i_instr_retire,
    input  logic [31:0]           i_dmem_rdata,
    input  logic [NUM_UART-1:0]   i_uart_tx_ready,
    input  logic [NUM_UART-1:0]   i_uart_rx_valid,
    input  logic [8*NUM_UART-1:0] i_uart_rx_data,
    output logic [3:0]            o_dmem_we,
    output logic [3:0]            o_imem_we,
    output logic [31:0]           o_mem_wdata,
    output logic [NUM_UART-1:0]   o_uart_tx_valid,
    output logic [7:0]            o_uart_tx_data,
    output logic [NUM_UART-1:0]   o_uart_rx_ready,
    output logic [31:0]           o_load_data,
    output logic                  o_misaligned
);

    typedef enum logic [1:0] {SrcNone, SrcDmem, SrcIo} src_e;

    logic              w_req;
    logic              w_acc;
    logic              w_io;
    logic              w_io_acc;
    logic              w_st_acc;
    logic [31:0]       w_off;
    logic [3:0]        w_we;
    logic [31:0]       w_wdata;
    logic [31:0]       w_io_rdata;
    logic              w_cnt_cyc_hit;
    logic              w_cnt_ins_hit;
    logic              w_cnt_clr;
    logic [31:0]       w_cycle_rd;
    logic [31:0]       w_instr_rd;
    logic [NUM_UART-1:0] w_stat_hit;
    logic [NUM_UART-1:0] w_rx_hit;
    logic [NUM_UART-1:0] w_tx_hit;
    logic [31:0]       w_chain [NUM_UART+1];
    logic [31:0]       w_src_val;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;

    logic [CNT_W-1:0]  r_cycle;
    logic [CNT_W-1:0]  r_instr;
    src_e              r_src;
    logic [1:0]        r_lane;
    logic [1:0]        r_size;
    logic              r_signed;
    logic [31:0]       r_io_rdata;

    assign w_req    = i_is_load | i_is_store;
    // Reset gates the access so that no strobe leaks out while the block is held in reset.
    assign w_acc    = w_req & ~i_stall & ~o_misaligned & ~i_rst;
    assign w_io     = i_addr[IO_BIT];
    assign w_io_acc = w_acc & w_io;
    assign w_st_acc = w_acc & i_is_store;
    assign w_off    = 32'(i_addr[IO_BIT-1:0]);

    // Flag sub-word or word accesses that do not sit on their natural boundary.
    always_comb begin
        o_misaligned = 1'b0;
        if (w_req) begin
            case (i_size)
                2'b00:   o_misaligned = 1'b0;
                2'b01:   o_misaligned = i_addr[0];
                default: o_misaligned = |i_addr[1:0];
            endcase
        end
    end

    // Store lane selection: replicate the data so every enabled lane sees the right bytes.
    always_comb begin
        w_we    = 4'b0000;
        w_wdata = 32'h0;
        case (i_size)
            2'b00: begin
                w_we    = 4'b0001 << i_addr[1:0];
                w_wdata = {4{i_store_data[7:0]}};
            end
            2'b01: begin
                w_we    = 4'b0011 << i_addr[1:0];
                w_wdata = {2{i_store_data[15:0]}};
            end
            default: begin
                w_we    = 4'b1111;
                w_wdata = i_store_data;
            end
        endcase
    end

    assign o_mem_wdata    = w_st_acc ? w_wdata : 32'h0;
    assign o_dmem_we      = (w_st_acc & ~w_io & i_addr[DMEM_BIT]) ? w_we : 4'b0000;
    assign o_imem_we      = (w_st_acc & ~w_io & i_addr[IMEM_BIT]) ? w_we : 4'b0000;
    assign o_uart_tx_data = i_store_data[7:0];

    // Per-channel register decode; read values are OR-chained since at most one channel hits.
    assign w_chain[0] = 32'h0;
    for (genvar c = 0; c < NUM_UART; c++) begin : g_uart
        localparam logic [31:0] Base = 32'(c * UART_STRIDE);
        assign w_stat_hit[c]      = w_io_acc & i_is_load & (w_off == Base);
        assign w_rx_hit[c]        = w_io_acc & i_is_load & (w_off == Base + 32'd4);
        assign w_tx_hit[c]        = w_io_acc & i_is_store & (w_off == Base + 32'd8);
        assign o_uart_rx_ready[c] = w_rx_hit[c];
        assign o_uart_tx_valid[c] = w_tx_hit[c];
        assign w_chain[c+1] = w_chain[c]
            | (w_stat_hit[c] ? {30'h0, i_uart_rx_valid[c], i_uart_tx_ready[c]} : 32'h0)
            | (w_rx_hit[c] ? {24'h0, i_uart_rx_data[8*c +: 8]} : 32'h0);
    end

    assign w_cycle_rd    = 32'(r_cycle);
    assign w_instr_rd    = 32'(r_instr);
    assign w_cnt_cyc_hit = w_io_acc & i_is_load & (w_off == CNT_OFFSET);
    assign w_cnt_ins_hit = w_io_acc & i_is_load & (w_off == CNT_OFFSET + 32'd4);
    assign w_cnt_clr     = w_io_acc & i_is_store & (w_off == CNT_OFFSET + 32'd8);
    assign w_io_rdata    = w_chain[NUM_UART]
                         | (w_cnt_cyc_hit ? w_cycle_rd : 32'h0)
                         | (w_cnt_ins_hit ? w_instr_rd : 32'h0);

    // Performance counters: cycle count runs through stalls; a clear beats the increment.
    always_ff @(posedge i_clk) begin
        if (i_rst || w_cnt_clr) begin
            r_cycle <= '0;
            r_instr <= '0;
        end else begin
            r_cycle <= r_cycle + 1'b1;
            if (i_instr_retire) begin
                r_instr <= r_instr + 1'b1;
            end
        end
    end

    // Load context register into writeback; I/O values are captured with their strobes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_src      <= SrcNone;
            r_lane     <= 2'b00;
            r_size     <= 2'b00;
            r_signed   <= 1'b0;
            r_io_rdata <= 32'h0;
        end else if (!i_stall) begin
            r_lane     <= i_addr[1:0];
            r_size     <= i_size;
            r_signed   <= i_load_signed;
            r_io_rdata <= w_io_rdata;
            if (w_acc && i_is_load) begin
                r_src <= w_io ? SrcIo : SrcDmem;
            end else begin
                r_src <= SrcNone;
            end
        end
    end

    // Writeback lane extraction and sign/zero extension.
    always_comb begin
        case (r_src)
            SrcDmem: w_src_val = i_dmem_rdata;
            SrcIo:   w_src_val = r_io_rdata;
            default: w_src_val = 32'h0;
        endcase
        w_byte = w_src_val[{r_lane, 3'b000} +: 8];
        w_half = r_lane[1] ? w_src_val[31:16] : w_src_val[15:0];
        case (r_size)
            2'b00:   o_load_data = {{24{r_signed & w_byte[7]}}, w_byte};
            2'b01:   o_load_data = {{16{r_signed & w_half[15]}}, w_half};
            default: o_load_data = w_src_val;
        endcase
    end

endmodule

// File: doc/mmio_mem_ctrl.md
Name: mmio_mem_ctrl

Overview:
- Parametrised memory and I/O access controller for the MIPS150 datapath.
- Decodes execute-stage load/store addresses into DMEM/IMEM byte write-enables, per-channel UART strobes, and cycle/instruction counter accesses.
- Registers the load context into the writeback stage and returns aligned, sign- or zero-extended load data one cycle later.
- Generalises the single-UART combinational decode to NUM_UART channels, sub-word stores, misalignment detection and performance counters.

Parameters:
NUM_UART, 2, number of UART channels (1..8)
UART_STRIDE, 32, byte spacing between UART channel register blocks
IO_BIT, 31, Addr bit selecting the I/O space
IMEM_BIT, 30, Addr bit enabling the IMEM write path (stores only)
DMEM_BIT, 28, Addr bit enabling the DMEM write path (stores only)
CNT_OFFSET, 32'h400, byte offset of the counter block within I/O space
CNT_W, 32, counter width

Ports:
Clock  in  1  system clock
Reset  in  1  synchronous, active-high reset
Stall  in  1  freeze: suppresses all strobes and holds the pipeline register
IsLoad  in  1  execute-stage load request
IsStore  in  1  execute-stage store request
Addr  in  32  byte address
Size  in  2  00 byte, 01 half, 10 word (11 is treated as word)
LoadSigned  in  1  sign-extend sub-word loads
StoreData  in  32  unshifted store data (rt)
InstrRetire  in  1  one instruction retired this cycle
DMemRData  in  32  synchronous DMEM read data (valid the cycle after the address)
UartTxReady  in  NUM_UART  per-channel transmitter ready
UartRxValid  in  NUM_UART  per-channel receive data valid
UartRxData  in  8*NUM_UART  channel c occupies bits [8c+7:8c]
DMemWE  out  4  DMEM byte write enables
IMemWE  out  4  IMEM byte write enables
MemWData  out  32  store data shifted to its byte lane
UartTxValid  out  NUM_UART  one-cycle transmit strobe
UartTxData  out  8  StoreData[7:0], shared by all channels
UartRxReady  out  NUM_UART  one-cycle receive-consume strobe
LoadData  out  32  writeback-stage load result
Misaligned  out  1  combinational misalignment flag

Behaviour:
- Reset:
  - All strobes, DMemWE, IMemWE, MemWData and LoadData are 0.
  - Both counters are 0. The pipeline register is cleared (load select = none).
- Access condition: Acc = (IsLoad|IsStore) & ~Stall & ~Misaligned.
- Misaligned:
  - Half access with Addr[0]=1, or word access with Addr[1:0]!=0.
  - When set, no strobes are issued. A misaligned load returns 0 in the next cycle.
- Store lanes (Acc & IsStore):
  - Byte: WE = 1<<Addr[1:0], data replicated to all four lanes.
  - Half: WE = 4'b0011<<Addr[1:0], data replicated to both halves.
  - Word: WE = 4'b1111.
- Store destinations:
  - Not I/O: DMemWE active if Addr[DMEM_BIT]; IMemWE active if Addr[IMEM_BIT]. Both may be active in the same cycle.
- I/O space (Addr[IO_BIT]=1); offset o = Addr[IO_BIT-1:0].
  - Channel c base = c*UART_STRIDE.
    - +0 status, read-only: {30'b0, UartRxValid[c], UartTxReady[c]}.
    - +4 rx data, read: pulses UartRxReady[c] for the access cycle.
    - +8 tx data, write: pulses UartTxValid[c]. No check against TxReady; software polls.
  - Counter block:
    - CNT_OFFSET+0: cycle count.
    - CNT_OFFSET+4: retired-instruction count.
    - CNT_OFFSET+8: any store clears both counters.
  - Unmapped I/O reads return 0. Unmapped I/O stores are ignored.
  - I/O stores never assert DMemWE or IMemWE.
- Strobes are combinational from the current request and last exactly one cycle per request.
- Load pipeline:
  - On Acc & IsLoad, the register captures source (DMEM / UART status / UART rx / counter / none), Addr[1:0], Size, LoadSigned, and the I/O read value.
  - I/O values are sampled in the request cycle, so rx data is coherent with its RxReady strobe.
  - Next cycle, LoadData = extracted lane from the source:
    - byte: lane Addr[1:0];
    - half: lane Addr[1];
    - sign- or zero-extended per LoadSigned.
  - DMEM source uses DMemRData in that cycle.
  - With no load captured, the register is loaded with source "none" and LoadData = 0.
  - When Stall=1, the register holds and LoadData is stable.
- Counters:
  - Cycle count increments every cycle, including during Stall.
  - Instr count increments when InstrRetire=1.
  - Both wrap modulo 2^CNT_W.
  - A clear store takes priority over the increment in the same cycle: value is 0 the next cycle.
- Reset mid-operation: a pending load result is discarded and LoadData = 0 on the cycle after Reset.

Test Plan:
- Byte store Addr=0x1000_0003, StoreData=0xAB, Size=00 -> DMemWE=4'b1000, MemWData=0xABABABAB, IMemWE=0.
- Word store Addr=0x5000_0000 -> DMemWE=IMemWE=4'b1111 in the same cycle; Stall=1 on the same request -> both 0.
- Signed byte load Addr=0x1000_0002, DMemRData=0x0080_0000 next cycle -> LoadData=0xFFFF_FF80; unsigned -> 0x0000_0080.
- Channel 1 rx read Addr=0x8000_0024, UartRxData[15:8]=0x5A -> UartRxReady=2'b10 for one cycle, LoadData=0x5A next cycle; status read at 0x8000_0020 with RxValid=1, TxReady=0 -> 0x2.
- Half store Addr=0x1000_0001 -> Misaligned=1, DMemWE=0; a misaligned load returns 0.
- After 10 cycles with 4 InstrRetire pulses, load cycle count at 0x8000_0400 and instr count at 0x8000_0404 -> 10 and 4; store to 0x8000_0408 -> both read 0 the next cycle, then count from 0; cycle count preset near 2^32-1 wraps to 0.
